// File: rtl/falu_wb_scheduler_if.sv
// Issue handshake and completion bus between the FP scheduler port and the
// FALU writeback scheduler.
interface falu_wb_scheduler_if #(
  parameter int MAX_LAT = 12,
  parameter int TAG_W   = 7,
  parameter int KM_W    = 4
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic             issue_valid;
  logic [LAT_W-1:0] issue_lat;
  logic [TAG_W-1:0] issue_tag;
  logic [KM_W-1:0]  issue_kmask;
  logic             issue_ready;
  logic             lat_err;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;

  modport master (
    output issue_valid, issue_lat, issue_tag, issue_kmask,
    input  issue_ready, lat_err, done_valid, done_tag
  );

  modport slave (
    input  issue_valid, issue_lat, issue_tag, issue_kmask,
    output issue_ready, lat_err, done_valid, done_tag
  );
endinterface

// File: rtl/falu_wb_scheduler.sv
// Writeback scheduler for the pipelined FP ALU. Each op reserves its
// result-bus slot at issue in a shift register indexed by remaining latency,
// so slot 0 is the op completing this cycle and no two ops share a cycle.
module falu_wb_scheduler #(
  parameter int MAX_LAT = 12,
  parameter int TAG_W   = 7,
  parameter int KM_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         kill_en,
  input  logic [KM_W-1:0]              kill_vmask,
  input  logic                         resolve_en,
  input  logic [KM_W-1:0]              resolve_mask,
  falu_wb_scheduler_if.slave           bus,
  output logic [$clog2(MAX_LAT+1)-1:0] inflight,
  output logic                         idle
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic [MAX_LAT-1:0] s_v;
  logic [TAG_W-1:0]   s_tag [MAX_LAT];
  logic [KM_W-1:0]    s_km  [MAX_LAT];

  logic [MAX_LAT-1:0] nxt_v;
  logic [TAG_W-1:0]   nxt_tag [MAX_LAT];
  logic [KM_W-1:0]    nxt_km  [MAX_LAT];

  logic [MAX_LAT-1:0] s_hit;
  logic [KM_W-1:0]    res_clr;
  logic               issue_hit;
  logic               lat_bad;
  logic               slot_busy;
  logic               accept;

  // Kill hits are judged on the masks as they stand, before any resolve.
  always_comb begin
    s_hit = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      s_hit[i] = kill_en & (|(s_km[i] & kill_vmask));
    end
    res_clr   = resolve_en ? resolve_mask : '0;
    issue_hit = kill_en & (|(bus.issue_kmask & kill_vmask));
  end

  // Issue handshake: the op needs the slot it will land in one cycle from now,
  // i.e. s[L] before the shift; L == MAX_LAT reads the always-empty virtual slot.
  always_comb begin
    lat_bad   = (bus.issue_lat == '0) || (bus.issue_lat > LAT_W'(MAX_LAT));
    slot_busy = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (bus.issue_lat == LAT_W'(i)) slot_busy = s_v[i];
    end
    bus.lat_err     = bus.issue_valid & lat_bad;
    bus.issue_ready = ~(bus.issue_valid & lat_bad) & ~slot_busy;
    accept          = bus.issue_valid & bus.issue_ready & ~flush;
  end

  // Next slot contents: shift toward slot 0, drop killed ops, clear resolved
  // branch bits, drop in the accepted op, and empty everything on flush.
  always_comb begin
    nxt_v = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      nxt_tag[i] = '0;
      nxt_km[i]  = '0;
    end
    for (int i = 0; i < MAX_LAT - 1; i++) begin
      nxt_v[i]   = s_v[i+1] & ~s_hit[i+1];
      nxt_tag[i] = s_tag[i+1];
      nxt_km[i]  = s_km[i+1] & ~res_clr;
    end
    for (int i = 0; i < MAX_LAT; i++) begin
      if (accept && (bus.issue_lat == LAT_W'(i + 1))) begin
        nxt_v[i]   = ~issue_hit;
        nxt_tag[i] = bus.issue_tag;
        nxt_km[i]  = bus.issue_kmask & ~res_clr;
      end
    end
    if (flush) nxt_v = '0;
  end

  // Slot register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_v <= '0;
      for (int i = 0; i < MAX_LAT; i++) begin
        s_tag[i] <= '0;
        s_km[i]  <= '0;
      end
    end else begin
      s_v <= nxt_v;
      for (int i = 0; i < MAX_LAT; i++) begin
        s_tag[i] <= nxt_tag[i];
        s_km[i]  <= nxt_km[i];
      end
    end
  end

  // Completion strobe straight from slot 0, suppressed by flush or a kill hit.
  always_comb begin
    bus.done_valid = s_v[0] & ~flush & ~s_hit[0];
    bus.done_tag   = bus.done_valid ? s_tag[0] : '0;
  end

  // Occupancy count of the slot register.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      inflight = inflight + LAT_W'(s_v[i]);
    end
    idle = (inflight == '0);
  end
endmodule

// File: tb/tb_falu_wb_scheduler.sv
// Directed bench for the FALU writeback scheduler with hand-computed results.
module tb_falu_wb_scheduler;
  localparam int MAX_LAT = 12;
  localparam int TAG_W   = 7;
  localparam int KM_W    = 4;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             kill_en;
  logic [KM_W-1:0]  kill_vmask;
  logic             resolve_en;
  logic [KM_W-1:0]  resolve_mask;
  logic [LAT_W-1:0] inflight;
  logic             idle;

  int n_cmp = 0;
  int n_mis = 0;

  falu_wb_scheduler_if #(.MAX_LAT(MAX_LAT), .TAG_W(TAG_W), .KM_W(KM_W)) bus ();

  falu_wb_scheduler #(.MAX_LAT(MAX_LAT), .TAG_W(TAG_W), .KM_W(KM_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .kill_en      (kill_en),
    .kill_vmask   (kill_vmask),
    .resolve_en   (resolve_en),
    .resolve_mask (resolve_mask),
    .bus          (bus),
    .inflight     (inflight),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_done(input string tag, input int v, input int t);
    check_val({tag, "_valid"}, 32'(bus.done_valid), 32'(v));
    check_val({tag, "_tag"}, 32'(bus.done_tag), 32'(t));
  endtask

  task automatic quiet();
    flush            = 1'b0;
    kill_en          = 1'b0;
    kill_vmask       = '0;
    resolve_en       = 1'b0;
    resolve_mask     = '0;
    bus.issue_valid  = 1'b0;
    bus.issue_lat    = LAT_W'(1);
    bus.issue_tag    = '0;
    bus.issue_kmask  = '0;
  endtask

  // Advance one cycle; inputs for the new cycle are driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    quiet();
  endtask

  task automatic put(input int tag, input int lat, input int km);
    bus.issue_valid = 1'b1;
    bus.issue_tag   = TAG_W'(tag);
    bus.issue_lat   = LAT_W'(lat);
    bus.issue_kmask = KM_W'(km);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    quiet();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_done("rst", 0, 0);
    check_val("rst_inflight", 32'(inflight), 32'd0);
    check_val("rst_idle", 32'(idle), 32'd1);
    check_val("rst_ready", 32'(bus.issue_ready), 32'd1);
    rst_n = 1'b1;

    // Latency: L=3 completes exactly three cycles later, L=1 next cycle.
    step(); put(5, 3, 0); #1;
    check_val("lat3_ready", 32'(bus.issue_ready), 32'd1);
    check_val("lat3_err", 32'(bus.lat_err), 32'd0);
    step(); #1;
    check_done("lat3_t1", 0, 0);
    check_val("lat3_inflight", 32'(inflight), 32'd1);
    step(); #1; check_done("lat3_t2", 0, 0);
    step(); #1; check_done("lat3_t3", 1, 5);
    step(); put(9, 1, 0); #1;
    check_done("lat3_t4", 0, 0);
    check_val("lat1_ready", 32'(bus.issue_ready), 32'd1);
    check_val("lat1_idle", 32'(idle), 32'd1);
    step(); #1; check_done("lat1_t1", 1, 9);
    step(); #1; check_done("lat1_t2", 0, 0);

    // Collision: B at L=3 would land on A's slot; L=2 is free.
    step(); put('h11, 4, 0); #1;
    check_val("colA_ready", 32'(bus.issue_ready), 32'd1);
    step(); put('h22, 3, 0); #1;
    check_val("colB3_ready", 32'(bus.issue_ready), 32'd0);
    bus.issue_lat = LAT_W'(2); #1;
    check_val("colB2_ready", 32'(bus.issue_ready), 32'd1);
    step(); #1; check_done("col_t2", 0, 0);
    step(); #1; check_done("col_t3", 1, 'h22);
    step(); #1; check_done("col_t4", 1, 'h11);
    step(); #1;
    check_done("col_t5", 0, 0);
    check_val("col_idle", 32'(idle), 32'd1);

    // Kill: vmask 0010 removes the 0010 and 0011 ops and a same-cycle issue.
    step(); put(1, 4, 1);
    step(); put(2, 4, 2);
    step(); put(3, 4, 3);
    step(); kill_en = 1'b1; kill_vmask = 4'b0010; put(4, 5, 2); #1;
    check_val("kill_issue_ready", 32'(bus.issue_ready), 32'd1);
    check_val("kill_inflight_pre", 32'(inflight), 32'd3);
    check_done("kill_c3", 0, 0);
    step(); #1;
    check_done("kill_c4", 1, 1);
    check_val("kill_inflight_post", 32'(inflight), 32'd1);
    for (int k = 5; k < 10; k++) begin
      step(); #1; check_done($sformatf("kill_c%0d", k), 0, 0);
    end
    check_val("kill_idle", 32'(idle), 32'd1);

    // Resolve clears the branch bit, so a later kill on it does not hit.
    step(); put('h30, 4, 1);
    step(); resolve_en = 1'b1; resolve_mask = 4'b0001;
    step(); kill_en = 1'b1; kill_vmask = 4'b0001; #1;
    check_val("res_inflight", 32'(inflight), 32'd1);
    step(); kill_en = 1'b1; kill_vmask = 4'b0001; #1;
    check_done("res_c3", 0, 0);
    step(); kill_en = 1'b1; kill_vmask = 4'b0001; #1;
    check_done("res_c4", 1, 'h30);

    // Latency range errors block the handshake and leave state untouched.
    step(); put('h40, 3, 0);
    step(); put('h41, 0, 0); #1;
    check_val("lat0_err", 32'(bus.lat_err), 32'd1);
    check_val("lat0_ready", 32'(bus.issue_ready), 32'd0);
    check_val("lat0_inflight", 32'(inflight), 32'd1);
    step(); put('h42, MAX_LAT + 1, 0); #1;
    check_val("lat13_err", 32'(bus.lat_err), 32'd1);
    check_val("lat13_ready", 32'(bus.issue_ready), 32'd0);
    check_val("lat13_inflight", 32'(inflight), 32'd1);
    step(); #1;
    check_done("laterr_c3", 1, 'h40);
    step(); put('h43, MAX_LAT, 0); flush = 1'b1; #1;
    check_val("lat12_err", 32'(bus.lat_err), 32'd0);
    check_val("lat12_ready", 32'(bus.issue_ready), 32'd1);
    step(); #1;
    check_val("laterr_idle", 32'(idle), 32'd1);

    // Back-to-back MAX_LAT ops: every one accepted, one completion per cycle.
    for (int c = 0; c < 30; c++) begin
      step();
      if (c < 16) put('h50 + c, MAX_LAT, 0);
      #1;
      if (c < 16) check_val($sformatf("b2b_ready%0d", c), 32'(bus.issue_ready), 32'd1);
      if (c >= 12 && c < 28) check_done($sformatf("b2b_c%0d", c), 1, 'h50 + c - 12);
      else                   check_done($sformatf("b2b_c%0d", c), 0, 0);
      if (c == 12) check_val("b2b_inflight", 32'(inflight), 32'd12);
    end

    // Flush with five in flight (oldest in slot 0) plus a concurrent issue.
    for (int k = 0; k < 5; k++) begin
      step(); put('h60 + k, 6, 0);
    end
    step();
    step(); flush = 1'b1; put('h70, 6, 0); #1;
    check_val("flush_inflight", 32'(inflight), 32'd5);
    check_val("flush_ready", 32'(bus.issue_ready), 32'd1);
    check_done("flush_c6", 0, 0);
    step(); #1;
    check_val("flush_idle", 32'(idle), 32'd1);
    check_val("flush_inflight_post", 32'(inflight), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step(); #1; check_done($sformatf("flush_after%0d", k), 0, 0);
    end

    // Asynchronous reset in the middle of traffic.
    step(); put(1, 5, 0);
    step(); put(2, 5, 0);
    step(); put(3, 5, 0);
    step(); #1;
    check_val("mrst_inflight_pre", 32'(inflight), 32'd3);
    rst_n = 1'b0; #1;
    check_done("mrst_now", 0, 0);
    check_val("mrst_inflight", 32'(inflight), 32'd0);
    check_val("mrst_idle", 32'(idle), 32'd1);
    check_val("mrst_ready", 32'(bus.issue_ready), 32'd1);
    step(); #1;
    check_val("mrst_inflight_next", 32'(inflight), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(); #1; check_done($sformatf("mrst_after%0d", k), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
